// File: rtl/bcrypt_expand_ctrl_pkg.sv
// Shared constants and state encoding for the bcrypt ExpandKey sequencer.
package bcrypt_pkg;
  localparam int ROUNDS       = 16;
  localparam int P_PAIRS      = 9;
  localparam int N_SRAM       = 4;
  localparam int SRAM_DEPTH   = 128;
  localparam int TOTAL_BLOCKS = P_PAIRS + N_SRAM * SRAM_DEPTH;

  localparam int ADDR_W = $clog2(SRAM_DEPTH);
  localparam int SRAM_W = $clog2(N_SRAM);
  localparam int BLK_W  = $clog2(TOTAL_BLOCKS);
  localparam int RND_W  = $clog2(ROUNDS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_KEYXOR,
    S_CLEAR,
    S_SALT,
    S_ROUND,
    S_FINAL,
    S_WB_P,
    S_WB_S,
    S_DONE
  } expand_state_t;
endpackage

// File: rtl/bcrypt_expand_ctrl_if.sv
// Command handshake and datapath strobe bundle between the cost loop, the sequencer and the Blowfish datapath.
interface bcrypt_expand_ctrl_if;
  import bcrypt_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_use_salt;
  logic              cmd_key_src;
  logic              busy;
  logic              done;
  logic              p_key_src;
  logic              p_key_xor;
  logic              lr_clear;
  logic              lr_salt_xor;
  logic              salt_half;
  logic              round_en;
  logic              final_en;
  logic              p_wb_en;
  logic [3:0]        p_wb_idx;
  logic [N_SRAM-1:0] s_we;
  logic [ADDR_W-1:0] s_waddr;

  modport master (
    output cmd_valid, cmd_use_salt, cmd_key_src,
    input  cmd_ready, busy, done, p_key_src, p_key_xor, lr_clear, lr_salt_xor,
           salt_half, round_en, final_en, p_wb_en, p_wb_idx, s_we, s_waddr
  );

  modport slave (
    input  cmd_valid, cmd_use_salt, cmd_key_src,
    output cmd_ready, busy, done, p_key_src, p_key_xor, lr_clear, lr_salt_xor,
           salt_half, round_en, final_en, p_wb_en, p_wb_idx, s_we, s_waddr
  );
endinterface

// File: rtl/bcrypt_expand_ctrl_wb_ctr.sv
// Writeback position tracking: global block index plus S-box SRAM select and address.
module bcrypt_wb_ctr
  import bcrypt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_inc_blk,
  input  logic              i_inc_s,
  output logic [3:0]        o_p_idx,
  output logic              o_salt_half,
  output logic [ADDR_W-1:0] o_addr,
  output logic [SRAM_W-1:0] o_sram,
  output logic              o_is_p_phase,
  output logic              o_is_last
);
  logic [BLK_W-1:0]  r_blk;
  logic [ADDR_W-1:0] r_addr;
  logic [SRAM_W-1:0] r_sram;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_blk  <= '0;
      r_addr <= '0;
      r_sram <= '0;
    end else begin
      if (i_inc_blk) r_blk <= r_blk + 1'b1;
      if (i_inc_s) begin
        r_addr <= r_addr + 1'b1;
        if (r_addr == ADDR_W'(SRAM_DEPTH - 1)) r_sram <= r_sram + 1'b1;
      end
    end
  end

  assign o_p_idx      = r_blk[3:0];
  assign o_salt_half  = r_blk[0];
  assign o_addr       = r_addr;
  assign o_sram       = r_sram;
  assign o_is_p_phase = (r_blk < BLK_W'(P_PAIRS));
  assign o_is_last    = (r_blk == BLK_W'(TOTAL_BLOCKS - 1));
endmodule

// File: rtl/bcrypt_expand_ctrl.sv
// Sequencer for one bcrypt ExpandKey pass; accepts a command only in IDLE and
// drives one datapath strobe per cycle until the one-cycle done pulse.
module bcrypt_expand_ctrl
  import bcrypt_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  bcrypt_expand_ctrl_if.slave bus
);
  expand_state_t     r_state;
  expand_state_t     w_next;
  expand_state_t     w_after_wb;
  logic [RND_W-1:0]  r_round_ctr;
  logic              r_use_salt;
  logic              r_key_src;
  logic              w_accept;
  logic              w_clr;
  logic              w_inc_blk;
  logic              w_inc_s;
  logic [3:0]        w_p_idx;
  logic              w_salt_half;
  logic [ADDR_W-1:0] w_addr;
  logic [SRAM_W-1:0] w_sram;
  logic              w_is_p_phase;
  logic              w_is_last;

  bcrypt_wb_ctr u_wb_ctr (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (w_clr),
    .i_inc_blk    (w_inc_blk),
    .i_inc_s      (w_inc_s),
    .o_p_idx      (w_p_idx),
    .o_salt_half  (w_salt_half),
    .o_addr       (w_addr),
    .o_sram       (w_sram),
    .o_is_p_phase (w_is_p_phase),
    .o_is_last    (w_is_last)
  );

  assign w_accept   = (r_state == S_IDLE) && bus.cmd_valid;
  assign w_after_wb = w_is_last ? S_DONE : (r_use_salt ? S_SALT : S_ROUND);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_round_ctr <= '0;
      r_use_salt  <= 1'b0;
      r_key_src   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_ROUND && r_round_ctr != RND_W'(ROUNDS - 1))
        r_round_ctr <= r_round_ctr + 1'b1;
      else
        r_round_ctr <= '0;
      if (w_accept) begin
        r_use_salt <= bus.cmd_use_salt;
        r_key_src  <= bus.cmd_key_src;
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    w_clr           = 1'b0;
    w_inc_blk       = 1'b0;
    w_inc_s         = 1'b0;
    bus.cmd_ready   = 1'b0;
    bus.done        = 1'b0;
    bus.p_key_xor   = 1'b0;
    bus.lr_clear    = 1'b0;
    bus.lr_salt_xor = 1'b0;
    bus.round_en    = 1'b0;
    bus.final_en    = 1'b0;
    bus.p_wb_en     = 1'b0;
    bus.s_we        = '0;
    case (r_state)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) w_next = S_KEYXOR;
      end
      S_KEYXOR: begin
        bus.p_key_xor = 1'b1;
        w_next        = S_CLEAR;
      end
      S_CLEAR: begin
        bus.lr_clear = 1'b1;
        w_clr        = 1'b1;
        w_next       = r_use_salt ? S_SALT : S_ROUND;
      end
      S_SALT: begin
        bus.lr_salt_xor = 1'b1;
        w_next          = S_ROUND;
      end
      S_ROUND: begin
        bus.round_en = 1'b1;
        if (r_round_ctr == RND_W'(ROUNDS - 1)) w_next = S_FINAL;
      end
      S_FINAL: begin
        bus.final_en = 1'b1;
        w_next       = w_is_p_phase ? S_WB_P : S_WB_S;
      end
      S_WB_P: begin
        bus.p_wb_en = 1'b1;
        w_inc_blk   = 1'b1;
        w_next      = w_after_wb;
      end
      S_WB_S: begin
        bus.s_we  = N_SRAM'(1) << w_sram;
        w_inc_s   = 1'b1;
        w_inc_blk = 1'b1;
        w_next    = w_after_wb;
      end
      S_DONE: begin
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.p_key_src = r_key_src;
  assign bus.p_wb_idx  = w_p_idx;
  assign bus.salt_half = w_salt_half;
  assign bus.s_waddr   = w_addr;
endmodule

// File: doc/bcrypt_expand_ctrl.md
Name: bcrypt_expand_ctrl

Overview:
Sequencer for one bcrypt ExpandKey pass over the Blowfish datapath (P-array shift register, Feistel L/R registers, 4 S-box SRAMs).
- Accepts one command per pass and issues every datapath control strobe: key XOR into P, L/R clear, optional salt XOR, 16 Feistel rounds, finalize, writeback.
- Writeback fills P0..P17 (9 pairs), then the 4×128 64-bit S-box words.
- The top-level cost loop issues commands back to back.

Parameters:
ROUNDS, 16, Feistel rounds per block
P_PAIRS, 9, P-array writeback pairs
N_SRAM, 4, S-box SRAM count
SRAM_DEPTH, 128, 64-bit words per SRAM (address width = $clog2(SRAM_DEPTH))

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_use_salt  in  1  XOR salt into L/R before each block
cmd_key_src  in  1  P XOR source: 0 = key, 1 = salt
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at pass completion
p_key_src  out  1  registered cmd_key_src, held for the whole pass
p_key_xor  out  1  XOR all P pairs with the selected source
lr_clear  out  1  L <= 0, R <= 0
lr_salt_xor  out  1  L/R ^= selected salt half
salt_half  out  1  block_idx[0]; selects salt words 31/63 vs 95/127
round_en  out  1  shift Feistel registers and rotate P by one
final_en  out  1  final whitening/swap cycle
p_wb_en  out  1  load L/R into P pair p_wb_idx
p_wb_idx  out  4  P pair index, 0..8
s_we  out  N_SRAM  one-hot SRAM write enable
s_waddr  out  7  SRAM write address

Behaviour:
- Reset (synchronous) goes to IDLE from any state, including mid-pass. Reset values: all strobes, done, busy and s_we are 0; cmd_ready = 1; counters, p_key_src and the latched use_salt are 0. No partial done is produced.
- Handshake: accept occurs when cmd_valid && cmd_ready. On accept, latch cmd_use_salt and cmd_key_src. Command inputs are ignored while busy.
- States: IDLE, KEYXOR, CLEAR, SALT, ROUND, FINAL, WB_P, WB_S, DONE.
- IDLE: on accept, go to KEYXOR.
- KEYXOR: p_key_xor = 1 for 1 cycle, then CLEAR.
- CLEAR: lr_clear = 1 for 1 cycle; block_idx is set to 0. Next state is SALT if use_salt, else ROUND.
- SALT: lr_salt_xor = 1 for 1 cycle, then ROUND.
- ROUND: round_en = 1 for exactly ROUNDS cycles, counted by round_ctr from 0 to ROUNDS-1. Then FINAL.
- FINAL: final_en = 1 for 1 cycle. Next state is WB_P if block_idx < P_PAIRS, else WB_S.
- WB_P: p_wb_en = 1 and p_wb_idx = block_idx, for 1 cycle.
- WB_S: s_we[sram_ctr] = 1 and s_waddr = addr_ctr, for 1 cycle.
- After either writeback: increment block_idx. Next state is SALT/ROUND (per use_salt), or DONE after the last block.
- Last block: block_idx = P_PAIRS + N_SRAM·SRAM_DEPTH − 1 = 520.
- S-box address order: addr_ctr increments per WB_S. On wrap from SRAM_DEPTH−1 to 0, sram_ctr increments. sram_ctr 0..3 is never exceeded; reaching block 520 terminates the pass.
- DONE: done = 1 for 1 cycle, then IDLE. cmd_ready rises in the cycle after done.
- salt_half = block_idx[0]. This is a global count; it does not restart at the P/S-box boundary.
- Strobes are mutually exclusive: at most one of p_key_xor, lr_clear, lr_salt_xor, round_en, final_en, p_wb_en, |s_we is high per cycle.
- Latency is counted from the accept cycle, with accept = cycle 0:
  - use_salt = 1: done at cycle 2 + 521·19 + 1 = 9902.
  - use_salt = 0: done at cycle 2 + 521·18 + 1 = 9381.
- Back-to-back: a new command is accepted at the earliest 1 cycle after done.

Decomposition:
- bcrypt_pkg holds:
  - the state enum (expand_state_t);
  - constants ROUNDS, P_PAIRS, N_SRAM, SRAM_DEPTH;
  - TOTAL_BLOCKS = P_PAIRS + N_SRAM·SRAM_DEPTH.
- One sub-module, bcrypt_wb_ctr: block_idx, addr_ctr and sram_ctr with clear/increment inputs, plus is_p_phase and is_last flags.
- The FSM and round counter stay in bcrypt_expand_ctrl.

Test Plan:
- Reset, then cmd_valid with use_salt = 1, key_src = 0 -> accept at cycle 0, p_key_xor at cycle 1, lr_clear at cycle 2, first lr_salt_xor at cycle 3, done at cycle 9902, cmd_ready back at 9903.
- use_salt = 0, key_src = 1 -> p_key_src = 1 held for the whole pass, lr_salt_xor never asserted, done at cycle 9381.
- Writeback trace -> p_wb_idx sequence is 0..8 exactly once each. Then 512 s_we pulses: s_we = 0001 for addr 0..127, then 0010, 0100, 1000. Last write is s_we = 1000, s_waddr = 127. salt_half = 1 on the first S-box block (block 9).
- Per-cycle assertion -> strobes are one-hot or zero every cycle. Exactly 16 round_en cycles between each salt/clear and its final_en.
- Assert reset during the ROUND state of block 200 -> next cycle all strobes are 0, cmd_ready = 1, and no done. A fresh command then completes at the nominal latency.
- Hold cmd_valid high continuously -> exactly one accept per pass; the second accept occurs in the cycle after done.
